flash_rx_framer: RTL and testbench

Deserializer and byte FIFO on the MISO side of the SPI flash controller. Samples `f_miso` on controller-supplied bit strobes while chip-select is active and packs bits MSB-first into bytes. Tags each byte with its position in the current transaction and buffers it for a valid/ready consumer (status-poll logic, readback checker). Detects overflow and transactions that end mid-byte.

---
 rtl/flash_rx_framer.sv | 167 ++++++++++++++++
 tb/tb_flash_rx_framer.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/flash_rx_framer.sv
// flash_rx_framer
//   MISO-side deserializer and byte FIFO for the SPI flash controller.
//   While chip-select is low, f_miso is sampled on each bit_valid strobe.
//   Bits are packed MSB-first into bytes. Each completed byte is tagged with
//   its index in the transaction and queued for a valid/ready consumer.
//
// Ports
//   clk        : sole clock, rising edge
//   n_rst      : synchronous active-low reset
//   f_cs       : flash chip-select, active-low (low = transaction in progress)
//   f_miso     : serial data from the flash
//   bit_valid  : one-cycle strobe per SCLK bit; f_miso is sampled in that cycle
//   rx_ready   : consumer takes the head entry when rx_valid is also high
//   clear_err  : clears the sticky error flags
//   rx_valid   : FIFO non-empty
//   rx_data    : head byte; the first-received bit is in [7]
//   rx_index   : byte index of the head in its transaction (saturates at 255)
//   rx_first   : head is byte 0 of its transaction
//   level      : FIFO occupancy
//   overflow   : sticky; a completed byte was dropped because the FIFO was full
//   frag       : sticky; chip-select rose with 1-7 bits pending
module flash_rx_framer #(
  parameter int FIFO_DEPTH = 8,
  parameter int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             f_cs,
  input  logic             f_miso,
  input  logic             bit_valid,
  input  logic             rx_ready,
  input  logic             clear_err,
  output logic             rx_valid,
  output logic [7:0]       rx_data,
  output logic [7:0]       rx_index,
  output logic             rx_first,
  output logic [LVL_W-1:0] level,
  output logic             overflow,
  output logic             frag
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic [7:0] shreg;
  logic [2:0] bit_cnt;
  logic [7:0] byte_idx;

  logic sample;
  logic byte_done;
  logic frag_set;

  logic [7:0] mem_data  [FIFO_DEPTH];
  logic [7:0] mem_idx   [FIFO_DEPTH];
  logic       mem_first [FIFO_DEPTH];

  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [LVL_W-1:0] count;

  logic full;
  logic pop;
  logic push;
  logic ovf_set;

  // The FSM state is simply a registered copy of chip-select. Sampling uses the
  // live f_cs so a strobe in the same cycle that f_cs falls is not lost.
  always_comb begin
    state_d   = state_q;
    sample    = 1'b0;
    byte_done = 1'b0;
    frag_set  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!f_cs) state_d = SHIFT;
      end
      SHIFT: begin
        if (f_cs) begin
          state_d  = IDLE;
          frag_set = (bit_cnt != 3'd0);
        end
      end
      default: state_d = IDLE;
    endcase
    sample    = bit_valid && !f_cs;
    byte_done = sample && (bit_cnt == 3'd7);
  end

  always_ff @(posedge clk) begin
    if (!n_rst) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      shreg    <= 8'd0;
      bit_cnt  <= 3'd0;
      byte_idx <= 8'd0;
    end else if (f_cs) begin
      // Outside a transaction the counters are held at zero, which also
      // discards any partial byte when chip-select rises early.
      bit_cnt  <= 3'd0;
      byte_idx <= 8'd0;
    end else if (sample) begin
      shreg   <= {shreg[6:0], f_miso};
      bit_cnt <= bit_cnt + 3'd1;
      if (bit_cnt == 3'd7 && byte_idx != 8'hFF) byte_idx <= byte_idx + 8'd1;
    end
  end

  assign rx_valid = (count != '0);
  assign full     = (count == LVL_W'(FIFO_DEPTH));
  assign pop      = rx_valid && rx_ready;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign push     = byte_done && (!full || pop);
  assign ovf_set  = byte_done && full && !pop;

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_data[i]  <= 8'd0;
        mem_idx[i]   <= 8'd0;
        mem_first[i] <= 1'b0;
      end
    end else begin
      if (push) begin
        mem_data[wr_ptr]  <= {shreg[6:0], f_miso};
        mem_idx[wr_ptr]   <= byte_idx;
        mem_first[wr_ptr] <= (byte_idx == 8'd0);
        wr_ptr            <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + LVL_W'(1);
        2'b01:   count <= count - LVL_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky flags: a set event in the same cycle as clear_err wins.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      overflow <= 1'b0;
      frag     <= 1'b0;
    end else begin
      if (ovf_set)        overflow <= 1'b1;
      else if (clear_err) overflow <= 1'b0;
      if (frag_set)       frag     <= 1'b1;
      else if (clear_err) frag     <= 1'b0;
    end
  end

  assign rx_data  = mem_data[rd_ptr];
  assign rx_index = mem_idx[rd_ptr];
  assign rx_first = mem_first[rd_ptr];
  assign level    = count;

endmodule

// File: tb/tb_flash_rx_framer.sv
// tb_flash_rx_framer
//   Directed bench for flash_rx_framer (FIFO_DEPTH = 8). A per-cycle vector
//   table covers a two-byte transaction; hand-written sequences cover overflow,
//   pop-while-full, sticky-flag priority, fragments and mid-transaction reset.
module tb_flash_rx_framer;

  logic       clk;
  logic       n_rst;
  logic       f_cs;
  logic       f_miso;
  logic       bit_valid;
  logic       rx_ready;
  logic       clear_err;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic [7:0] rx_index;
  logic       rx_first;
  logic [3:0] level;
  logic       overflow;
  logic       frag;

  int checks;
  int errors;

  flash_rx_framer #(.FIFO_DEPTH(8)) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .f_cs      (f_cs),
    .f_miso    (f_miso),
    .bit_valid (bit_valid),
    .rx_ready  (rx_ready),
    .clear_err (clear_err),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .rx_index  (rx_index),
    .rx_first  (rx_first),
    .level     (level),
    .overflow  (overflow),
    .frag      (frag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       cs;
    logic       bv;
    logic       miso;
    logic       rdy;
    logic       clr;
    logic       chk_head;
    logic       vld;
    logic [7:0] dat;
    logic [7:0] idx;
    logic       first;
    logic [3:0] lvl;
    logic       ovf;
    logic       frg;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic cs, input logic bv, input logic miso,
                              input logic rdy, input logic chk_head, input logic vld,
                              input logic [7:0] dat, input logic [7:0] idx,
                              input logic first, input logic [3:0] lvl);
    vec_t v;
    v.cs = cs; v.bv = bv; v.miso = miso; v.rdy = rdy; v.clr = 1'b0;
    v.chk_head = chk_head; v.vld = vld; v.dat = dat; v.idx = idx;
    v.first = first; v.lvl = lvl; v.ovf = 1'b0; v.frg = 1'b0;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Drives 8 back-to-back strobes MSB-first; rdy/clr apply on the last strobe.
  task automatic send_byte(input logic [7:0] b, input logic rdy_last, input logic clr_last);
    for (int i = 7; i >= 0; i--) begin
      bit_valid = 1'b1;
      f_miso    = b[i];
      rx_ready  = (i == 0) ? rdy_last : 1'b0;
      clear_err = (i == 0) ? clr_last : 1'b0;
      tick();
    end
    bit_valid = 1'b0;
    rx_ready  = 1'b0;
    clear_err = 1'b0;
  endtask

  task automatic pop_check(input string nm, input logic [7:0] d, input logic [7:0] ix,
                           input logic fst);
    chk({nm, ".valid"}, 32'(rx_valid), 32'd1);
    chk({nm, ".data"},  32'(rx_data),  32'(d));
    chk({nm, ".index"}, 32'(rx_index), 32'(ix));
    chk({nm, ".first"}, 32'(rx_first), 32'(fst));
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
  endtask

  initial begin
    logic [7:0] b05;
    logic [7:0] ba3;
    logic [7:0] bytes2 [9];
    logic [7:0] bytes4 [9];

    checks = 0;
    errors = 0;
    n_rst = 1'b0; f_cs = 1'b1; f_miso = 1'b0;
    bit_valid = 1'b0; rx_ready = 1'b0; clear_err = 1'b0;

    // ---- vector table: one transaction carrying 0x05 then 0xA3 ----
    b05 = 8'h05;
    ba3 = 8'hA3;
    for (int i = 7; i >= 1; i--)
      vq.push_back(mk(1'b0, 1'b1, b05[i], 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 4'd0));
    vq.push_back(mk(1'b0, 1'b1, b05[0], 1'b0, 1'b1, 1'b1, 8'h05, 8'h00, 1'b1, 4'd1));
    for (int i = 7; i >= 1; i--)
      vq.push_back(mk(1'b0, 1'b1, ba3[i], 1'b0, 1'b1, 1'b1, 8'h05, 8'h00, 1'b1, 4'd1));
    vq.push_back(mk(1'b0, 1'b1, ba3[0], 1'b0, 1'b1, 1'b1, 8'h05, 8'h00, 1'b1, 4'd2));
    vq.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'hA3, 8'h01, 1'b0, 4'd1));
    vq.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 4'd0));
    // Strobe with chip-select high is ignored
    vq.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 4'd0));

    for (int k = 0; k < 9; k++) begin
      bytes2[k] = 8'(k * 29 + 7);
      bytes4[k] = 8'(k * 53 + 100);
    end

    // ---- reset state ----
    tick();
    tick();
    chk("rst.valid",    32'(rx_valid), 32'd0);
    chk("rst.level",    32'(level),    32'd0);
    chk("rst.overflow", 32'(overflow), 32'd0);
    chk("rst.frag",     32'(frag),     32'd0);
    chk("rst.data",     32'(rx_data),  32'd0);
    chk("rst.index",    32'(rx_index), 32'd0);
    chk("rst.first",    32'(rx_first), 32'd0);
    n_rst = 1'b1;
    tick();

    foreach (vq[r]) begin
      f_cs = vq[r].cs; bit_valid = vq[r].bv; f_miso = vq[r].miso;
      rx_ready = vq[r].rdy; clear_err = vq[r].clr;
      tick();
      chk($sformatf("vec%0d.ctl{vld,lvl,ovf,frag}", r),
          32'({rx_valid, level, overflow, frag}),
          32'({vq[r].vld, vq[r].lvl, vq[r].ovf, vq[r].frg}));
      if (vq[r].chk_head)
        chk($sformatf("vec%0d.head{data,idx,first}", r),
            32'({rx_data, rx_index, rx_first}),
            32'({vq[r].dat, vq[r].idx, vq[r].first}));
    end
    bit_valid = 1'b0; rx_ready = 1'b0;

    // ---- overflow with clear_err on the dropping cycle, then drain ----
    f_cs = 1'b0;
    for (int k = 0; k < 8; k++) send_byte(bytes2[k], 1'b0, 1'b0);
    chk("ovf.level_full", 32'(level),    32'd8);
    chk("ovf.pre_flag",   32'(overflow), 32'd0);
    send_byte(bytes2[8], 1'b0, 1'b1);
    chk("ovf.level_after_drop", 32'(level),    32'd8);
    chk("ovf.set_beats_clear",  32'(overflow), 32'd1);
    chk("ovf.head_kept",        32'(rx_data),  32'(bytes2[0]));
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    chk("ovf.cleared", 32'(overflow), 32'd0);
    f_cs = 1'b1;
    for (int k = 0; k < 8; k++)
      pop_check($sformatf("drain%0d", k), bytes2[k], 8'(k), (k == 0));
    chk("drain.level", 32'(level),    32'd0);
    chk("drain.valid", 32'(rx_valid), 32'd0);
    chk("drain.frag",  32'(frag),     32'd0);

    // ---- full FIFO with pop on the exact completing cycle ----
    f_cs = 1'b0;
    for (int k = 0; k < 8; k++) send_byte(bytes4[k], 1'b0, 1'b0);
    send_byte(bytes4[8], 1'b1, 1'b0);
    chk("fullpop.level",    32'(level),    32'd8);
    chk("fullpop.overflow", 32'(overflow), 32'd0);
    for (int k = 1; k < 8; k++)
      pop_check($sformatf("fullpop%0d", k), bytes4[k], 8'(k), 1'b0);
    pop_check("fullpop.new", bytes4[8], 8'd8, 1'b0);
    chk("fullpop.empty", 32'(level), 32'd0);
    f_cs = 1'b1;
    tick();

    // ---- 12 strobes then chip-select high, then a fresh 0x8C ----
    f_cs = 1'b0;
    send_byte(8'h3C, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      bit_valid = 1'b1;
      f_miso    = i[0];
      tick();
    end
    bit_valid = 1'b0;
    chk("frag.level_before", 32'(level), 32'd1);
    chk("frag.clear_before", 32'(frag),  32'd0);
    f_cs = 1'b1;
    pop_check("frag.whole", 8'h3C, 8'd0, 1'b1);
    chk("frag.set",   32'(frag),  32'd1);
    chk("frag.empty", 32'(level), 32'd0);
    f_cs = 1'b0;
    send_byte(8'h8C, 1'b0, 1'b0);
    chk("frag.new_level", 32'(level), 32'd1);
    f_cs = 1'b1;
    pop_check("frag.new", 8'h8C, 8'd0, 1'b1);
    chk("frag.sticky", 32'(frag), 32'd1);

    // ---- reset mid-transaction with f_cs held low ----
    f_cs = 1'b0;
    send_byte(8'h11, 1'b0, 1'b0);
    send_byte(8'h22, 1'b0, 1'b0);
    send_byte(8'h33, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      bit_valid = 1'b1;
      f_miso    = 1'b0;
      tick();
    end
    bit_valid = 1'b0;
    chk("mrst.level_before", 32'(level), 32'd3);
    n_rst = 1'b0;
    tick();
    n_rst = 1'b1;
    chk("mrst.level",    32'(level),    32'd0);
    chk("mrst.valid",    32'(rx_valid), 32'd0);
    chk("mrst.overflow", 32'(overflow), 32'd0);
    chk("mrst.frag",     32'(frag),     32'd0);
    chk("mrst.data",     32'(rx_data),  32'd0);
    send_byte(8'hFF, 1'b0, 1'b0);
    chk("mrst.new_level", 32'(level), 32'd1);
    pop_check("mrst.new", 8'hFF, 8'd0, 1'b1);
    f_cs = 1'b1;
    tick();
    chk("mrst.no_frag", 32'(frag), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
